// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multiplier/divider between two requesters: round-robin grant in IDLE,
// watchdog-protected unit wait, and a held response until the owner accepts it.
module ibex_multdiv_arbiter #(
  parameter int unsigned WDOG_CYCLES = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_operator_i,
  input  logic [1:0]  req0_signed_mode_i,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_operator_i,
  input  logic [1:0]  req1_signed_mode_i,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        rsp1_err_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  input  logic        unit_valid_i,
  input  logic [31:0] unit_result_i,
  output logic        busy_o
);

  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [1:0]  operator_q, operator_d;
  logic [1:0]  signed_q, signed_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic grant_id;
  logic accept;
  logic active;
  logic owner_rsp_rdy;

  assign active = !rst_i;

  // ptr_q holds the last winner; on a tie the other requester goes next.
  always_comb begin
    grant_id = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = !ptr_q;
    end
  end

  assign req0_ready_o  = active && (state_q == IDLE) && req0_valid_i && !grant_id;
  assign req1_ready_o  = active && (state_q == IDLE) && req1_valid_i && grant_id;
  assign accept        = req0_ready_o || req1_ready_o;
  assign owner_rsp_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    operator_d = operator_q;
    signed_d   = signed_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d    = grant_id;
          ptr_d      = grant_id;
          operator_d = grant_id ? req1_operator_i    : req0_operator_i;
          signed_d   = grant_id ? req1_signed_mode_i : req0_signed_mode_i;
          op_a_d     = grant_id ? req1_op_a_i        : req0_op_a_i;
          op_b_d     = grant_id ? req1_op_b_i        : req0_op_b_i;
          wdog_d     = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + WDW'(1);
        // A completion in the terminal-count cycle still counts as success.
        if (unit_valid_i) begin
          result_d = unit_result_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
          result_d = 32'hFFFF_FFFF;
          err_d    = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      owner_q    <= 1'b0;
      operator_q <= 2'b00;
      signed_q   <= 2'b00;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      result_q   <= 32'h0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      operator_q <= operator_d;
      signed_q   <= signed_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Outputs are forced quiet while reset is held so an aborted op never leaks.
  assign busy_o        = active && (state_q != IDLE);
  assign mult_en_o     = active && (state_q == BUSY) && !operator_q[1];
  assign div_en_o      = active && (state_q == BUSY) && operator_q[1];
  assign operator_o    = active ? operator_q : 2'b00;
  assign signed_mode_o = active ? signed_q : 2'b00;
  assign op_a_o        = active ? op_a_q : 32'h0;
  assign op_b_o        = active ? op_b_q : 32'h0;

  assign rsp0_valid_o  = active && (state_q == RESP) && !owner_q;
  assign rsp1_valid_o  = active && (state_q == RESP) && owner_q;
  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;
  assign rsp0_err_o    = err_q;
  assign rsp1_err_o    = err_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with a response scoreboard queue.
module tb_ibex_multdiv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req0_sm, req1_op, req1_sm;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic        mult_en, div_en, unit_valid, busy;
  logic [1:0]  operator, signed_mode;
  logic [31:0] op_a, op_b, unit_result;

  typedef struct packed {
    logic        owner;
    logic [31:0] result;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ibex_multdiv_arbiter #(.WDOG_CYCLES(40)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_operator_i(req0_op), .req0_signed_mode_i(req0_sm),
    .req0_op_a_i(req0_a), .req0_op_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_operator_i(req1_op), .req1_signed_mode_i(req1_sm),
    .req1_op_a_i(req1_a), .req1_op_b_i(req1_b),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp0_result_o(rsp0_result), .rsp0_err_o(rsp0_err),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp1_result_o(rsp1_result), .rsp1_err_o(rsp1_err),
    .mult_en_o(mult_en), .div_en_o(div_en),
    .operator_o(operator), .signed_mode_o(signed_mode),
    .op_a_o(op_a), .op_b_o(op_b),
    .unit_valid_i(unit_valid), .unit_result_i(unit_result),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic rspv(input logic id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_en"}, {mult_en, div_en}, 2'b00);
    chk({tag, "_rdy"}, {req0_ready, req1_ready}, 2'b00);
    chk({tag, "_rspv"}, {rsp0_valid, rsp1_valid}, 2'b00);
    chk({tag, "_ops"}, op_a | op_b | 32'(operator) | 32'(signed_mode), 32'h0);
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_op = op; req1_sm = 2'b10; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_sm = 2'b01; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  // Returns one cycle after the handshake, i.e. in the first BUSY cycle.
  task automatic accept(input logic id, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic err);
    int n;
    drive_req(id, op, a, b);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      cyc();
      #1;
      n++;
    end
    chk("accept_ready", id ? req1_ready : req0_ready, 1'b1);
    sb.push_back('{owner: id, result: res, err: err});
    cyc();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic collect(input logic id, input int hold);
    int n;
    exp_t e;
    logic [31:0] r0;
    n = 0;
    while (!rspv(id) && n < 100) begin
      cyc();
      n++;
    end
    chk("rsp_valid", rspv(id), 1'b1);
    chk("rsp_other_valid", rspv(!id), 1'b0);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_owner", id, e.owner);
      chk("rsp_result", id ? rsp1_result : rsp0_result, e.result);
      chk("rsp_err", id ? rsp1_err : rsp0_err, e.err);
    end
    r0 = id ? rsp1_result : rsp0_result;
    for (int k = 0; k < hold; k++) begin
      cyc();
      chk("hold_valid", rspv(id), 1'b1);
      chk("hold_result", id ? rsp1_result : rsp0_result, r0);
      chk("hold_no_accept", {req0_ready, req1_ready}, 2'b00);
    end
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("rsp_done_valid", rspv(id), 1'b0);
  endtask

  task automatic unit_done(input int delay, input logic [31:0] res);
    if (delay > 0) cyc(delay);
    unit_valid = 1'b1;
    unit_result = res;
    cyc();
    unit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    unit_valid = 1'b0; unit_result = 32'h0;
    cyc(2);
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b0; req0_sm = 2'b0; req0_a = 32'h0; req0_b = 32'h0;
    req1_op = 2'b0; req1_sm = 2'b0; req1_a = 32'h0; req1_b = 32'h0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    unit_valid = 1'b0; unit_result = 32'h0;

    // Reset: quiet outputs during and after, requests not accepted while held.
    cyc(2);
    check_quiet("rst_during");
    req0_valid = 1'b1;
    #1;
    chk("rst_ready_gated", req0_ready, 1'b0);
    req0_valid = 1'b0;
    rst = 1'b0;
    cyc();
    check_quiet("rst_after");

    // Single MULL 7*6 with unit completing at T+3.
    accept(1'b0, 2'd0, 32'd7, 32'd6, 32'd42, 1'b0);
    chk("mul_busy", busy, 1'b1);
    chk("mul_en_t1", {mult_en, div_en}, 2'b10);
    chk("mul_ops", {op_a, op_b}, {32'd7, 32'd6});
    chk("mul_operator", {signed_mode, operator}, 4'b0100);
    cyc();
    chk("mul_en_t2", mult_en, 1'b1);
    cyc();
    unit_valid = 1'b1;
    unit_result = 32'd42;
    chk("mul_en_t3", mult_en, 1'b1);
    cyc();
    unit_valid = 1'b0;
    chk("mul_en_t4", mult_en, 1'b0);
    chk("mul_rsp_t4", rsp0_valid, 1'b1);
    collect(1'b0, 0);
    chk("mul_idle", busy, 1'b0);

    // Round-robin tie handling.
    do_reset();
    drive_req(1'b0, 2'd1, 32'd3, 32'd5);
    drive_req(1'b1, 2'd3, 32'd9, 32'd4);
    #1;
    chk("tie1_grant", {req0_ready, req1_ready}, 2'b10);
    sb.push_back('{owner: 1'b0, result: 32'h55, err: 1'b0});
    cyc();
    req0_valid = 1'b0;
    chk("tie1_busy_rdy", req1_ready, 1'b0);
    cyc();
    chk("tie1_busy_rdy2", req1_ready, 1'b0);
    unit_done(0, 32'h55);
    collect(1'b0, 0);
    #1;
    chk("tie2_grant", {req0_ready, req1_ready}, 2'b01);
    sb.push_back('{owner: 1'b1, result: 32'h1, err: 1'b0});
    cyc();
    req1_valid = 1'b0;
    chk("rem_div_en", {mult_en, div_en}, 2'b01);
    unit_done(1, 32'h1);
    collect(1'b1, 0);
    drive_req(1'b0, 2'd0, 32'd2, 32'd2);
    drive_req(1'b1, 2'd0, 32'd3, 32'd3);
    #1;
    chk("tie3_grant", {req0_ready, req1_ready}, 2'b10);
    sb.push_back('{owner: 1'b0, result: 32'd4, err: 1'b0});
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    unit_done(0, 32'd4);
    collect(1'b0, 0);

    // DIV from requester 1: enables and operator held until completion.
    accept(1'b1, 2'd2, 32'd100, 32'd7, 32'd14, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("div_en", {mult_en, div_en}, 2'b01);
      chk("div_operator", operator, 2'd2);
      chk("div_op_a", op_a, 32'd100);
      cyc();
    end
    unit_done(0, 32'd14);
    collect(1'b1, 0);

    // Watchdog abort after 40 BUSY cycles, one DRAIN cycle, then error response.
    accept(1'b0, 2'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      chk("wdog_busy_en", mult_en, 1'b1);
      cyc();
    end
    chk("drain_en", {mult_en, div_en}, 2'b00);
    chk("drain_busy", busy, 1'b1);
    chk("drain_no_rsp", rsp0_valid, 1'b0);
    cyc();
    chk("wdog_rsp_t42", rsp0_valid, 1'b1);
    collect(1'b0, 0);

    // Completion on the terminal-count cycle wins over the watchdog.
    accept(1'b1, 2'd2, 32'd5, 32'd5, 32'h1234, 1'b0);
    cyc(39);
    unit_valid = 1'b1;
    unit_result = 32'h1234;
    chk("coinc_en", div_en, 1'b1);
    cyc();
    unit_valid = 1'b0;
    chk("coinc_rsp", rsp1_valid, 1'b1);
    collect(1'b1, 0);

    // Response backpressure with a competing request waiting.
    accept(1'b0, 2'd1, 32'd2, 32'd3, 32'd6, 1'b0);
    unit_done(1, 32'd6);
    drive_req(1'b1, 2'd0, 32'd4, 32'd5);
    #1;
    collect(1'b0, 5);
    #1;
    chk("bp_req1_after", req1_ready, 1'b1);
    accept(1'b1, 2'd0, 32'd4, 32'd5, 32'd20, 1'b0);
    unit_done(0, 32'd20);
    collect(1'b1, 0);

    // Reset mid-operation drops the operation and ignores a late completion.
    accept(1'b0, 2'd0, 32'd8, 32'd8, 32'd64, 1'b0);
    chk("rstbusy_en", mult_en, 1'b1);
    cyc();
    rst = 1'b1;
    #1;
    chk("rstbusy_during_en", {mult_en, div_en, busy}, 3'b000);
    cyc();
    rst = 1'b0;
    sb.delete();
    check_quiet("rstbusy_after");
    unit_valid = 1'b1;
    unit_result = 32'd99;
    cyc();
    unit_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_unit_ignored", {busy, rsp0_valid, rsp1_valid}, 3'b000);
      cyc();
    end
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_arbiter.md
IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 40, the max cycles to wait for unit valid_i before abort.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i, input, 1 each, the requester N operation request.
REQ-005 SHALL have ports req0_ready_o / req1_ready_o, output, 1 each, the request accept strobe.
REQ-006 SHALL have ports reqN_operator_i, input, 2, with encoding 0=MULL, 1=MULH, 2=DIV, 3=REM.
REQ-007 SHALL have ports reqN_signed_mode_i, input, 2, the signedness of op_a/op_b.
REQ-008 SHALL have ports reqN_op_a_i and reqN_op_b_i, input, 32 each, the operands.
REQ-009 SHALL have ports rspN_valid_o (output, 1), rspN_ready_i (input, 1), rspN_result_o (output, 32) and rspN_err_o (output, 1), the response channel.
REQ-010 SHALL have ports mult_en_o and div_en_o, output, 1 each, the unit enables.
REQ-011 SHALL have ports operator_o (2), signed_mode_o (2), op_a_o (32) and op_b_o (32), all outputs, the unit operands.
REQ-012 SHALL have ports unit_valid_i (input, 1) and unit_result_i (input, 32), the unit completion and result.
REQ-013 SHALL have port busy_o, output, 1, high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP, DRAIN.
REQ-015 In IDLE, grant SHALL be combinational: one valid requester wins; if both are valid, the requester not granted last wins (round-robin pointer).
REQ-016 reqN_ready_o SHALL be high only in IDLE for the granted requester; at most one ready is high per cycle.
REQ-017 On a handshake (valid & ready) in cycle T, the block SHALL latch operator, signed_mode, operands and owner ID, update the pointer to the owner, and enter BUSY at T+1.
REQ-018 In BUSY, div_en_o SHALL equal operator[1] and mult_en_o SHALL equal !operator[1]; exactly one enable SHALL be high and held constant until exit; operand outputs SHALL be stable.
REQ-019 In BUSY, unit_valid_i SHALL latch unit_result_i, clear err, and move to RESP the next cycle; enables SHALL be low from that next cycle.
REQ-020 A watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle; if it reaches WDOG_CYCLES with unit_valid_i low, the block SHALL latch result 32'hFFFF_FFFF, set err=1, and go to DRAIN.
REQ-021 DRAIN SHALL last exactly one cycle with both enables low (the unit restarts), then go to RESP.
REQ-022 In RESP, rsp[owner]_valid_o SHALL be high and result/err stable until rsp[owner]_ready_i; on that handshake the block SHALL return to IDLE the next cycle.
REQ-023 rspN_valid_o SHALL be low for the non-owner at all times.
REQ-024 unit_valid_i outside BUSY SHALL be ignored.
REQ-025 Request inputs SHALL be ignored outside IDLE; a requester keeping valid high waits without loss.
REQ-026 Minimum latency SHALL be: accept T, enable T+1, valid_i at V, rsp valid at V+1; back-to-back accept no earlier than the cycle after the response handshake.
REQ-027 When unit_valid_i and the watchdog terminal count coincide, valid_i SHALL win (no error).

Reset
REQ-028 While rst_i is high at a clock edge: state=IDLE, pointer=req1 (so req0 wins the first tie), watchdog=0, latched result=0, err=0.
REQ-029 During and immediately after reset, all enables, readys, rsp valids and busy_o SHALL be 0 and operand outputs 0; reset in BUSY/RESP SHALL abort the operation and drop the pending response.

Verification
REQ-030 Single MUL: req0 MULL a=7 b=6 accepted at T, unit_valid_i with 42 at T+3 -> mult_en_o high T+1..T+3, rsp0_valid_o at T+4 with result 42, err=0.
REQ-031 Tie: both valid after reset -> req0 granted first; after completion with req1 still valid -> req1 granted; both valid again -> req0 granted.
REQ-032 DIV enable: req1 DIV a=100 b=7 -> div_en_o=1, mult_en_o=0, operator_o=2 held until valid_i; rsp1 result equals unit_result_i (14).
REQ-033 Watchdog: unit_valid_i never asserted -> after 40 BUSY cycles one DRAIN cycle with enables low, then rsp valid with 32'hFFFF_FFFF and err=1.
REQ-034 Backpressure: rsp0_ready_i low 5 cycles -> rsp0_valid_o and result held stable, req1 not accepted until after the handshake.
REQ-035 Reset in BUSY: rst_i high mid-operation -> next cycle IDLE, enables 0, no response emitted, later unit_valid_i ignored.
